// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W0..W63, one per
// cycle, while holding the external round counter in reset outside of a run.
module sha256_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [16*WORD_W-1:0]     block_in_i,
    input  logic [5:0]               round_i,
    output logic                     count_reset_o,
    output logic [WORD_W-1:0]        w_out_o,
    output logic                     w_valid_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     sync_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [5:0] T_LAST  = 6'(ROUNDS - 1);

    logic [1:0]              state_q, state_d;
    logic [15:0][WORD_W-1:0] win_q, win_d;
    logic [5:0]              t_q, t_d;
    logic                    cr_q, cr_d;
    logic                    se_q, se_d;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        cr_d    = cr_q;
        se_d    = se_q;
        case (state_q)
            ST_IDLE: begin
                cr_d = 1'b1;
                if (start_i) begin
                    // W0 sits in the top word of the block and lands at the window head
                    for (int i = 0; i < 16; i++)
                        win_d[i] = block_in_i[WORD_W*(15-i) +: WORD_W];
                    t_d     = '0;
                    cr_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < 15; i++)
                    win_d[i] = win_q[i+1];
                win_d[15] = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
                t_d = t_q + 6'd1;
                if (round_i != t_q)
                    se_d = 1'b1;
                // Reassert the counter reset on the last round so it cannot wrap into a second pass
                if (t_q == T_LAST) begin
                    cr_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cr_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                cr_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            t_q     <= '0;
            cr_q    <= 1'b1;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
            cr_q    <= cr_d;
            se_q    <= se_d;
        end
    end

    assign count_reset_o = cr_q;
    assign w_valid_o     = (state_q == ST_RUN);
    assign busy_o        = (state_q == ST_RUN);
    assign done_o        = (state_q == ST_DONE);
    assign sync_err_o    = se_q;
    assign w_out_o       = (state_q == ST_RUN) ? win_q[0] : '0;

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule stage that consumes the 6-bit round index produced by the round counter.
- Loads a 512-bit block, emits W_t for t = 0..63, one word per cycle, in lockstep with the counter.
- Owns the counter's reset line: holds the counter at 0 while idle and releases it for exactly 64 rounds.
- Sits between the block loader (upstream) and the compression round datapath (downstream).

Parameters:
- WORD_W, 32, schedule word width (fixed by SHA-256; not for override).
- ROUNDS, 64, rounds per block; must equal the counter modulus.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to load block_in; honoured only in IDLE.
- block_in  input  512  message block; W0 = [511:480] ... W15 = [31:0].
- round  input  6  current round index from the 6-bit round counter.
- count_reset  output  1  registered; drives the round counter's reset.
- w_out  output  32  W_t for the current round.
- w_valid  output  1  w_out is valid for round index t.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after W63 is emitted.
- sync_err  output  1  sticky; round index disagreed with the internal index.

Behaviour:
- Reset values:
  - state = IDLE, count_reset = 1, w_valid = 0, busy = 0, done = 0, sync_err = 0.
  - w_out = 0; the 16-word window and the internal index t_int are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - count_reset = 1.
  - On start = 1: window[0..15] <= W0..W15, t_int <= 0, state <= RUN, count_reset <= 0.
- RUN (cycle S+1 through S+64, where S is the start cycle):
  - w_out = window[0] (combinational from the window head); w_valid = 1; busy = 1.
  - Each cycle the window shifts down one word.
  - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t_int increments each cycle.
  - If round != t_int in any RUN cycle: sync_err <= 1 (sticky). Operation continues.
- Exit from RUN: in the cycle where t_int = 63, state <= DONE and count_reset <= 1. The counter therefore returns to 0 and does not wrap to a second pass.
- DONE: done = 1, w_valid = 0, busy = 0; next state is IDLE.
- Latency: start sampled at S; W0 at S+1; W63 at S+64; done at S+65. Next start is accepted from S+66.
- start in RUN or DONE: ignored, with no effect on the window.
- block_in: sampled only on the accepted start cycle.
- reset mid-RUN: at the next edge all state returns to reset values, including count_reset = 1. Any partial schedule is discarded and done does not pulse.
- sync_err: cleared only by reset.
- Arithmetic: all additions are unsigned 32-bit with carry-out discarded.

Test Plan:
- "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), start at S -> required response:
  - W0 = 0x61626380 at S+1.
  - W16 = 0x61626380.
  - W17 = 0x000F0000.
  - All 64 words match the golden SHA-256 model.
  - done pulses exactly once, at S+65.
- Reset state and idle: hold reset 3 cycles, then idle 5 cycles -> count_reset = 1 throughout; w_valid = busy = done = sync_err = 0; round stays at 0.
- start pulsed at S+10 and again in the DONE cycle, with a different block_in -> both ignored; the output stream is identical to the first block; no restart.
- reset asserted at S+30 -> at S+31: state IDLE, count_reset = 1, w_valid = 0, no done pulse. A new start then produces a correct schedule from W0.
- Back-to-back blocks: start at S+66 with an all-ones block -> W16 = 0x? per the golden model; round restarts at 0 on S+67; sync_err = 0.
- round forced to 5 when t_int = 4 -> sync_err = 1 from the next cycle and remains 1 until reset; w_out values are unaffected.
